stop_watch_ctrl: RTL and testbench
==================================

STOP_WATCH_CTRL -- requirements
Module: stop_watch_ctrl

Interface
REQ-001 Parameter DB_TICKS, default 1_000_000: number of consecutive stable cycles before a button level is accepted.
REQ-002 Parameter BLINK_DIV, default 25_000_000: half-period in cycles of the lap blink.
REQ-003 clk  input  1  system clock; every register is clocked on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  raw start/stop button, asynchronous to clk.
REQ-006 btn_lap  input  1  raw lap button, asynchronous to clk.
REQ-007 btn_clr  input  1  raw clear button, asynchronous to clk.
REQ-008 d3, d2, d1, d0  input  4 each  live BCD digits from the stopwatch counter.
REQ-009 go  output  1  count-enable to the stopwatch counter.
REQ-010 clr  output  1  one-cycle synchronous clear to the stopwatch counter.
REQ-011 disp3, disp2, disp1, disp0  output  4 each  digits sent to the display multiplexer.
REQ-012 dp_out  output  4  decimal-point pattern sent to the display multiplexer.
REQ-013 lap_active  output  1  high while the display shows frozen lap digits.

Function
REQ-014 Each button input SHALL pass through a 2-flop synchroniser, followed by a debouncer that accepts a new level only after DB_TICKS consecutive equal samples.
REQ-015 A rising edge of a debounced level SHALL produce a one-cycle pulse: start_p, lap_p or clr_p.
REQ-016 The FSM SHALL have four states:
- IDLE: stopped.
- RUN: counting, live display.
- LAP: counting, frozen display.
- PAUSE: stopped, live display.
REQ-017 Pulse priority when pulses coincide SHALL be clr_p > start_p > lap_p; the lower-priority pulses are discarded that cycle.
REQ-018 clr_p SHALL, in any state, move the FSM to IDLE, assert clr for exactly one cycle, and zero the lap register.
REQ-019 IDLE: start_p SHALL move to RUN; lap_p SHALL be ignored.
REQ-020 RUN: start_p SHALL move to PAUSE; lap_p SHALL load {d3,d2,d1,d0} into the lap register and move to LAP.
REQ-021 LAP: lap_p SHALL return to RUN (display goes live); start_p SHALL move to PAUSE (display goes live, lap register retained).
REQ-022 PAUSE: start_p SHALL move to RUN; lap_p SHALL be ignored.
REQ-023 go SHALL be registered and equal 1 exactly when the state is RUN or LAP.
REQ-024 The disp outputs SHALL equal the lap register in LAP and the live d inputs combinationally in every other state.
REQ-025 lap_active SHALL equal 1 exactly in LAP.
REQ-026 dp_out SHALL be 4'b0101 outside LAP.
REQ-027 State, go and clr SHALL update on the clock edge following the pulse cycle; a button press SHALL reach go within DB_TICKS+4 cycles.
REQ-028 A button held down SHALL generate exactly one pulse; a glitch shorter than DB_TICKS cycles SHALL generate none.
REQ-029 The debounce counter SHALL saturate and never wrap; the blink counter SHALL wrap from BLINK_DIV-1 to 0.

Reset
REQ-030 While reset_n=0, state SHALL be IDLE and go=0, clr=0, lap register=0, lap_active=0, dp_out=4'b0101.
REQ-031 While reset_n=0, debounced levels, synchronisers and all counters SHALL be 0.
REQ-032 Reset asserted mid-LAP or mid-debounce SHALL abort immediately, with no pulse emitted after release until a fresh DB_TICKS-stable press.

Configuration
REQ-033 With macro STOP_WATCH_LAP_BLINK_EN defined, dp_out in LAP SHALL alternate between 4'b0101 and 4'b0000 every BLINK_DIV cycles, starting at 4'b0000 on LAP entry.
REQ-034 Without STOP_WATCH_LAP_BLINK_EN, the blink counter SHALL be absent and dp_out SHALL be 4'b0101 in all states.

Verification (DB_TICKS=4, BLINK_DIV=8)
REQ-035 Reset release, then btn_start held 10 cycles -> go=1 within 8 cycles, exactly one start_p.
REQ-036 In RUN with d=4'h1,2,3,4, press btn_lap, then drive d=4'h5,6,7,8 -> disp stays 1,2,3,4, lap_active=1, go=1; press btn_lap again -> disp=5,6,7,8.
REQ-037 In LAP, press btn_start -> PAUSE, go=0, disp live, lap_active=0.
REQ-038 btn_clr and btn_start rise in the same cycle while in RUN -> clr high exactly 1 cycle, state IDLE, go=0.
REQ-039 A 3-cycle btn_start glitch -> no pulse, state unchanged; reset_n pulsed low in LAP -> IDLE, all outputs at reset values.
REQ-040 With STOP_WATCH_LAP_BLINK_EN defined and the FSM in LAP -> dp_out toggles 0000/0101 every 8 cycles; without the macro -> dp_out constant 0101.

Source files
------------

// File: rtl/stop_watch_ctrl.sv
// Stopwatch front panel: synchronised/debounced buttons drive a run/lap/pause FSM and display mux.
// Optional lap blink of the decimal points is enabled with `define STOP_WATCH_LAP_BLINK_EN.

module stop_watch_debounce #(
   parameter int DB_TICKS = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic pulse
);
   localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

   logic [1:0]    sync;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   // cnt counts consecutive samples that disagree with the accepted level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync    <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], btn};
         level_q <= level;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_TICKS - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign pulse = level & ~level_q;
endmodule

module stop_watch_ctrl #(
   parameter int DB_TICKS  = 1_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   output logic       go,
   output logic       clr,
   output logic [3:0] disp3,
   output logic [3:0] disp2,
   output logic [3:0] disp1,
   output logic [3:0] disp0,
   output logic [3:0] dp_out,
   output logic       lap_active
);
   typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

   if (DB_TICKS < 2 || BLINK_DIV < 2) begin : g_param_check
      $error("stop_watch_ctrl: DB_TICKS and BLINK_DIV must be at least 2");
   end

   state_t      state;
   state_t      nxt;
   logic        load_lap;
   logic [15:0] lap_q;
   logic        start_p;
   logic        lap_p;
   logic        clr_p;

   stop_watch_debounce #(.DB_TICKS(DB_TICKS)) u_db_start (
      .clk(clk), .reset_n(reset_n), .btn(btn_start), .pulse(start_p));
   stop_watch_debounce #(.DB_TICKS(DB_TICKS)) u_db_lap (
      .clk(clk), .reset_n(reset_n), .btn(btn_lap), .pulse(lap_p));
   stop_watch_debounce #(.DB_TICKS(DB_TICKS)) u_db_clr (
      .clk(clk), .reset_n(reset_n), .btn(btn_clr), .pulse(clr_p));

   // Priority clr > start > lap; losing pulses are simply dropped
   always_comb begin
      nxt      = state;
      load_lap = 1'b0;
      if (clr_p) begin
         nxt = IDLE;
      end else if (start_p) begin
         case (state)
            IDLE, PAUSE: nxt = RUN;
            RUN, LAP:    nxt = PAUSE;
            default:     nxt = IDLE;
         endcase
      end else if (lap_p) begin
         case (state)
            RUN: begin
               nxt      = LAP;
               load_lap = 1'b1;
            end
            LAP:     nxt = RUN;
            default: nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         go    <= 1'b0;
         clr   <= 1'b0;
         lap_q <= '0;
      end else begin
         state <= nxt;
         go    <= (nxt == RUN) || (nxt == LAP);
         clr   <= clr_p;
         if (clr_p)
            lap_q <= '0;
         else if (load_lap)
            lap_q <= {d3, d2, d1, d0};
      end
   end

   assign lap_active = (state == LAP);
   assign {disp3, disp2, disp1, disp0} = lap_active ? lap_q : {d3, d2, d1, d0};

`ifdef STOP_WATCH_LAP_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV);

   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   // Held at zero outside LAP so every LAP entry starts on the dark phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b0;
      end else if (nxt != LAP || state != LAP) begin
         blink_cnt <= '0;
         blink_on  <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   assign dp_out = (lap_active && !blink_on) ? 4'b0000 : 4'b0101;
`else
   assign dp_out = 4'b0101;
`endif
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Randomised bench for stop_watch_ctrl (DB_TICKS=4, BLINK_DIV=8) against a mode-level reference model.
// Build with or without STOP_WATCH_LAP_BLINK_EN; dp_out expectations follow the same macro.

module tb_stop_watch_ctrl;
  localparam int DB = 4;
  localparam int BD = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_start, btn_lap, btn_clr;
  logic [3:0] d3, d2, d1, d0;
  logic       go, clr, lap_active;
  logic [3:0] disp3, disp2, disp1, disp0, dp_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          clr_cnt = 0;
  int          m_state;
  logic [15:0] lap_val;
  logic [15:0] d_val;

  stop_watch_ctrl #(.DB_TICKS(DB), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .go(go), .clr(clr),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .dp_out(dp_out), .lap_active(lap_active)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (clr) clr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [15:0] v);
    d_val = v;
    {d3, d2, d1, d0} = v;
    #1;
  endtask

  // reference model: operates on accepted presses, not on cycles
  task automatic model_press(input bit s, input bit l, input bit c);
    if (c) begin
      m_state = M_IDLE;
      lap_val = '0;
    end else if (s) begin
      m_state = (m_state == M_IDLE || m_state == M_PAUSE) ? M_RUN : M_PAUSE;
    end else if (l) begin
      if (m_state == M_RUN) begin
        m_state = M_LAP;
        lap_val = d_val;
      end else if (m_state == M_LAP) begin
        m_state = M_RUN;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] exp_disp;
    exp_disp = (m_state == M_LAP) ? lap_val : d_val;
    check({tag, "_go"}, go, (m_state == M_RUN || m_state == M_LAP));
    check({tag, "_lap_active"}, lap_active, (m_state == M_LAP));
    check({tag, "_disp"}, {disp3, disp2, disp1, disp0}, exp_disp);
`ifdef STOP_WATCH_LAP_BLINK_EN
    if (m_state != M_LAP) check({tag, "_dp"}, dp_out, 4'b0101);
`else
    check({tag, "_dp"}, dp_out, 4'b0101);
`endif
  endtask

  // driver: hold the chosen buttons, release, let everything settle, then check
  task automatic press(input bit s, input bit l, input bit c, input int hold, input string tag);
    int c0;
    c0 = clr_cnt;
    btn_start = s; btn_lap = l; btn_clr = c;
    repeat (hold) tick();
    btn_start = 0; btn_lap = 0; btn_clr = 0;
    repeat (10) tick();
    if (hold >= DB) model_press(s, l, c);
    check({tag, "_clr_cycles"}, clr_cnt - c0, (hold >= DB && c) ? 1 : 0);
    check_outputs(tag);
  endtask

  initial begin
    int lat;
    int k0;
    int exp_dp;
    btn_start = 0; btn_lap = 0; btn_clr = 0;
    reset_n = 0;
    m_state = M_IDLE;
    lap_val = '0;
    set_d(16'h0000);
    repeat (3) tick();
    set_d(16'h4321);
    check("rst_clr", clr, 1'b0);
    check_outputs("rst");
    reset_n = 1;
    tick();

    // start held 10 cycles: go within DB+4 cycles, exactly one toggle
    lat = 0;
    btn_start = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (go && lat == 0) lat = i;
    end
    btn_start = 0;
    check("start_latency_ok", (lat > 0 && lat <= DB + 4), 1'b1);
    repeat (10) tick();
    m_state = M_RUN;
    check_outputs("start_held");

    // lap freeze and release
    set_d(16'h1234);
    press(0, 1, 0, 6, "lap_in");
    set_d(16'h5678);
    check_outputs("lap_frozen");
    press(0, 1, 0, 5, "lap_out");

    // LAP -> PAUSE via start
    press(0, 1, 0, 4, "lap_in2");
    set_d(16'h9abc);
    press(1, 0, 0, 4, "lap_to_pause");

    // coinciding clr + start in RUN
    press(1, 0, 0, 5, "resume");
    press(1, 0, 1, 6, "clr_start");

    // short glitch ignored
    press(1, 0, 0, 3, "glitch");

    // lap blink phases
    press(1, 0, 0, 4, "run_for_blink");
    set_d(16'h2468);
    btn_lap = 1;
    k0 = -1;
    for (int i = 0; i < 20 && k0 < 0; i++) begin
      tick();
      if (lap_active) k0 = i;
    end
    check("blink_lap_entry_seen", (k0 >= 0), 1'b1);
    for (int k = 0; k < 24; k++) begin
`ifdef STOP_WATCH_LAP_BLINK_EN
      exp_dp = ((k / BD) % 2 == 0) ? 0 : 5;
`else
      exp_dp = 5;
`endif
      check($sformatf("blink_dp_k%0d", k), dp_out, exp_dp[3:0]);
      tick();
    end
    btn_lap = 0;
    repeat (10) tick();
    m_state = M_LAP;
    lap_val = d_val;
    set_d(16'h1357);
    check_outputs("blink_done");

    // asynchronous reset in LAP
    reset_n = 0;
    #1;
    m_state = M_IDLE;
    lap_val = '0;
    check("rst_lap_clr", clr, 1'b0);
    check_outputs("rst_in_lap");
    tick();
    reset_n = 1;
    repeat (3) tick();

    // reset in the middle of a debounce
    btn_start = 1;
    repeat (3) tick();
    reset_n = 0;
    tick();
    btn_start = 0;
    tick();
    reset_n = 1;
    repeat (12) tick();
    check_outputs("rst_mid_db");

    // randomised presses
    for (int n = 0; n < 60; n++) begin
      int sel;
      bit s, l, c;
      set_d(16'($urandom_range(0, 16'hffff)));
      sel = $urandom_range(0, 9);
      s = (sel inside {0, 1, 2, 6, 8});
      l = (sel inside {3, 4, 5, 6, 7});
      c = (sel inside {7, 8, 9}) && ($urandom_range(0, 2) == 0);
      if (!s && !l && !c) l = 1;
      press(s, l, c, $urandom_range(1, 7), $sformatf("rnd%0d", n));
      set_d(16'($urandom_range(0, 16'hffff)));
      check_outputs($sformatf("rnd%0d_newd", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
